// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // A one-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, bout set when that borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b mod 2^WIDTH, one bit per clock,
// LSB first, through a single full-subtractor cell and a registered borrow.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] sd_r;
  logic [WIDTH-1:0] sd_next_s;
  logic [WIDTH-1:0] diff_r;
  logic [CNT_W-1:0] cnt_r;
  logic             borrow_r;
  logic             borrow_out_r;
  logic             busy_r;
  logic             done_r;
  logic             d_s;
  logic             bout_s;

  full_subtractor u_cell (
    .a    (sa_r[0]),
    .b    (sb_r[0]),
    .bin  (borrow_r),
    .d    (d_s),
    .bout (bout_s)
  );

  // The new difference bit enters at the MSB; a 1-bit result is just the bit.
  generate
    if (WIDTH == 1) begin : g_sd_one
      assign sd_next_s = d_s;
    end else begin : g_sd_wide
      assign sd_next_s = {d_s, sd_r[WIDTH-1:1]};
    end
  endgenerate

  // Control FSM, serial datapath and registered result/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      sa_r         <= '0;
      sb_r         <= '0;
      sd_r         <= '0;
      cnt_r        <= '0;
      borrow_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      diff_r       <= '0;
      borrow_out_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            sa_r     <= a;
            sb_r     <= b;
            sd_r     <= '0;
            borrow_r <= 1'b0;
            cnt_r    <= '0;
            busy_r   <= 1'b1;
            state_r  <= ST_SHIFT;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          sa_r     <= sa_r >> 1;
          sb_r     <= sb_r >> 1;
          sd_r     <= sd_next_s;
          borrow_r <= bout_s;
          cnt_r    <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) begin
            diff_r       <= sd_next_s;
            borrow_out_r <= bout_s;
            busy_r       <= 1'b0;
            done_r       <= 1'b1;
            state_r      <= ST_DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign diff       = diff_r;
  assign borrow_out = borrow_out_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH 8, 4 and 1, compared
// against plain modular arithmetic.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a_s;
  logic [7:0] b_s;
  logic       start8, start4, start1;
  logic       busy8, done8, bo8;
  logic       busy4, done4, bo4;
  logic       busy1, done1, bo1;
  logic [7:0] diff8;
  logic [3:0] diff4;
  logic [0:0] diff1;

  int n_tests = 0;
  int n_fail  = 0;
  int sel     = 8;

  logic       obs_busy, obs_done, obs_bo;
  logic [7:0] obs_diff;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a_s), .b(b_s),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8));
  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a_s[3:0]), .b(b_s[3:0]),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4));
  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a_s[0:0]), .b(b_s[0:0]),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1));

  always_comb begin
    obs_busy = busy8; obs_done = done8; obs_bo = bo8; obs_diff = diff8;
    if (sel == 4) begin
      obs_busy = busy4; obs_done = done4; obs_bo = bo4; obs_diff = {4'h0, diff4};
    end else if (sel == 1) begin
      obs_busy = busy1; obs_done = done1; obs_bo = bo1; obs_diff = {7'h00, diff1};
    end
  end

  function automatic logic [7:0] model_diff(input int w, input logic [7:0] av, input logic [7:0] bv);
    logic [7:0] mask;
    mask = (w == 8) ? 8'hFF : (w == 4) ? 8'h0F : 8'h01;
    return (av - bv) & mask;
  endfunction

  task automatic set_start(input int w, input logic v);
    start8 = (w == 8) ? v : 1'b0;
    start4 = (w == 4) ? v : 1'b0;
    start1 = (w == 1) ? v : 1'b0;
  endtask

  // Runs one operation; returns at the negedge after the done cycle.
  task automatic do_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                       output logic [7:0] d, output logic bo, output int busy_cyc,
                       output int lat, output logic done_after);
    sel = w;
    a_s = av; b_s = bv;
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
    a_s = 8'($urandom); b_s = 8'($urandom);
    lat = 1; busy_cyc = 0;
    while (!obs_done && lat < 100) begin
      if (obs_busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    d = obs_diff; bo = obs_bo;
    @(negedge clk);
    done_after = obs_done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_s = 8'h00; b_s = 8'h00;
    set_start(8, 1'b0);
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy8, done8, diff8, bo8} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b diff=%h bo=%b, want all 0", busy8, done8, diff8, bo8);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_op(input string name, input int w, input logic [7:0] av, input logic [7:0] bv);
    logic [7:0] d; logic bo, da; int bc, lat;
    do_op(w, av, bv, d, bo, bc, lat, da);
    n_tests++;
    if (lat !== w + 1 || da !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_timing: got latency=%0d done_after=%b, want %0d and 0", name, lat, da, w + 1);
    end
    n_tests++;
    if (d !== model_diff(w, av, bv) || bo !== (av < bv)) begin
      n_fail++;
      $display("FAIL %s: a=%h b=%h got diff=%h bo=%b, want diff=%h bo=%b",
               name, av, bv, d, bo, model_diff(w, av, bv), av < bv);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d; logic bo, da; int bc, lat;
    do_op(8, 8'h5A, 8'h3C, d, bo, bc, lat, da);
    n_tests++;
    if (d !== 8'h1E || bo !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_5A_3C: got diff=%h bo=%b, want 1e 0", d, bo);
    end
    n_tests++;
    if (bc !== 8 || lat !== 9 || da !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_handshake: got busy_cycles=%0d latency=%0d done_after=%b, want 8 9 0", bc, lat, da);
    end
  endtask

  task automatic test_corners();
    check_op("zero_minus_one", 8, 8'h00, 8'h01);
    check_op("ff_minus_ff", 8, 8'hFF, 8'hFF);
  endtask

  task automatic test_ignore_start();
    logic [7:0] d; logic bo, da, hold_bad; int bc, lat, dones;
    do_op(8, 8'h00, 8'h01, d, bo, bc, lat, da);
    a_s = 8'h10; b_s = 8'h01;
    set_start(8, 1'b1);
    @(negedge clk);
    set_start(8, 1'b0);
    dones = 0; hold_bad = 1'b0; d = 8'h00; bo = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      if (done8) begin
        dones++; d = diff8; bo = bo8;
      end else if (busy8 && diff8 !== 8'hFF) begin
        hold_bad = 1'b1;
      end
      start8 = (i == 2 || i == 5 || done8);
      a_s = 8'h00; b_s = 8'h80;
      @(negedge clk);
    end
    start8 = 1'b0;
    n_tests++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL ignore_single_done: got %0d done pulses, want 1", dones);
    end
    n_tests++;
    if (d !== 8'h0F || bo !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_result: got diff=%h bo=%b, want 0f 0", d, bo);
    end
    n_tests++;
    if (hold_bad !== 1'b0) begin
      n_fail++;
      $display("FAIL diff_hold: got diff changed during SHIFT, want ff held");
    end
  endtask

  task automatic test_async_reset();
    logic saw_done;
    sel = 8;
    a_s = 8'h44; b_s = 8'h11;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy8, done8, diff8, bo8} !== 11'd0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b done=%b diff=%h bo=%b, want all 0", busy8, done8, diff8, bo8);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8 || busy8) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: got activity after reset, want none");
    end
    check_op("after_reset_03_05", 8, 8'h03, 8'h05);
  endtask

  task automatic test_back_to_back();
    check_op("b2b_80_7f", 8, 8'h80, 8'h7F);
    check_op("b2b_7f_80", 8, 8'h7F, 8'h80);
  endtask

  task automatic test_random8();
    for (int i = 0; i < 20; i++) begin
      check_op("rand8", 8, 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_sweep4();
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        check_op("sweep4", 4, 8'(x), 8'(y));
      end
    end
  endtask

  task automatic test_width1();
    for (int x = 0; x < 2; x++) begin
      for (int y = 0; y < 2; y++) begin
        check_op("width1", 1, 8'(x), 8'(y));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_random8();
    test_sweep4();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
